// File: rtl/bus_stall_responder_if.sv
// Device-side req/gnt/rvalid bus bundle.
// The host drives the request fields; the device answers with grant and response.
interface bus_stall_responder_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
);
    logic                    req;
    logic                    gnt;
    logic [AddressWidth-1:0] addr;
    logic                    we;
    logic [3:0]              be;
    logic [DataWidth-1:0]    wdata;
    logic                    rvalid;
    logic [DataWidth-1:0]    rdata;
    logic                    err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/bus_stall_responder.sv
// Memory-backed req/gnt/rvalid device with programmable grant stalls,
// fixed in-order response latency and a bound on outstanding requests.
module bus_stall_responder #(
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int Depth          = 1024,
    parameter int GntStall       = 0,
    parameter int RespLatency    = 1,
    parameter int MaxOutstanding = 2
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    bus_stall_responder_if.slave bus
);
    localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int Lanes = DataWidth / 8;

    logic [AddressWidth-1:0] word_idx;
    logic [IdxW-1:0]         mem_idx;
    logic                    in_range;
    logic                    room;
    logic                    acc;
    logic                    rvalid;
    logic [DataWidth-1:0]    rd_word;
    logic                    unused_addr;

    logic [3:0] stall_q, stall_d;
    logic [3:0] out_q, out_d;

    logic [RespLatency-1:0] valid_q, valid_d;
    logic [RespLatency-1:0] err_q, err_d;
    logic [DataWidth-1:0]   data_q [RespLatency];
    logic [DataWidth-1:0]   data_d [RespLatency];

    logic [DataWidth-1:0] mem_q [Depth];

    // Word index is compared at full width so high addresses never alias.
    assign word_idx    = {2'b00, bus.addr[AddressWidth-1:2]};
    assign mem_idx     = word_idx[IdxW-1:0];
    assign in_range    = word_idx < AddressWidth'(Depth);
    assign unused_addr = ^bus.addr[1:0];
    assign rd_word     = mem_q[mem_idx];

    // A retiring response frees its slot in the same cycle.
    assign rvalid = rst_ni && valid_q[RespLatency-1];
    assign room   = (out_q < 4'(MaxOutstanding)) || rvalid;
    assign acc    = bus.req && rst_ni
                    && (stall_q == 4'(GntStall)) && room;

    assign bus.gnt    = acc;
    assign bus.rvalid = rvalid;
    assign bus.err    = rst_ni && err_q[RespLatency-1];
    assign bus.rdata  = rst_ni ? data_q[RespLatency-1] : '0;

    // Next-state for stall counter, outstanding count and response pipe.
    always_comb begin
        stall_d = stall_q;
        if (!bus.req || acc) begin
            stall_d = 4'd0;
        end else if (stall_q != 4'(GntStall)) begin
            stall_d = stall_q + 4'd1;
        end

        out_d = out_q + {3'b000, acc} - {3'b000, rvalid};

        valid_d    = '0;
        err_d      = '0;
        valid_d[0] = acc;
        err_d[0]   = acc && !in_range;
        data_d[0]  = '0;
        if (acc && !bus.we && in_range) begin
            data_d[0] = rd_word;
        end
        for (int i = 1; i < RespLatency; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // Control and response-pipe registers; reset drops in-flight responses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_q <= 4'd0;
            out_q   <= 4'd0;
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            stall_q <= stall_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < RespLatency; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Byte-lane memory write at acceptance; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (acc && bus.we && in_range) begin
            for (int b = 0; b < Lanes; b++) begin
                if (bus.be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    a_out_bound : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        out_q <= 4'(MaxOutstanding)
    );

    a_no_orphan_resp : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(rvalid && (out_q == 4'd0))
    );
endmodule

// File: tb/tb_bus_stall_responder.sv
// Directed bench for bus_stall_responder.
// Four instances cover default, stalled, deep-latency and reset cases.
module tb_bus_stall_responder;
    logic clk = 1'b0;
    logic rst0_n, rst1_n, rst2_n, rst3_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bus_stall_responder_if b0 ();
    bus_stall_responder_if b1 ();
    bus_stall_responder_if b2 ();
    bus_stall_responder_if b3 ();

    bus_stall_responder u0 (
        .clk_i (clk),
        .rst_ni(rst0_n),
        .bus   (b0)
    );

    bus_stall_responder #(.GntStall(3)) u1 (
        .clk_i (clk),
        .rst_ni(rst1_n),
        .bus   (b1)
    );

    bus_stall_responder #(.RespLatency(4), .MaxOutstanding(2)) u2 (
        .clk_i (clk),
        .rst_ni(rst2_n),
        .bus   (b2)
    );

    bus_stall_responder #(.RespLatency(3)) u3 (
        .clk_i (clk),
        .rst_ni(rst3_n),
        .bus   (b3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated access on u0 (no stall, latency 1).
    task automatic acc0(input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
        step();
        b0.req   = 1'b1;
        b0.we    = w;
        b0.addr  = a;
        b0.be    = be;
        b0.wdata = wd;
        @(negedge clk);
        check({tag, ".gnt"}, 32'(b0.gnt), 32'd1);
        check({tag, ".rv_early"}, 32'(b0.rvalid), 32'd0);
        step();
        b0.req = 1'b0;
        b0.we  = 1'b0;
        @(negedge clk);
        check({tag, ".rvalid"}, 32'(b0.rvalid), 32'd1);
        check({tag, ".rdata"}, b0.rdata, exp_rd);
        check({tag, ".err"}, 32'(b0.err), 32'(exp_err));
    endtask

    logic [31:0] s_addr [6];
    logic        s_we   [6];
    logic [31:0] s_wd   [6];
    logic [31:0] s_rd   [6];
    logic        s_err  [6];

    initial begin
        int  k;
        int  r;
        logic eg;
        logic ev;

        b0.req = 0; b0.we = 0; b0.addr = 0; b0.be = 0; b0.wdata = 0;
        b1.req = 0; b1.we = 0; b1.addr = 0; b1.be = 0; b1.wdata = 0;
        b2.req = 0; b2.we = 0; b2.addr = 0; b2.be = 0; b2.wdata = 0;
        b3.req = 0; b3.we = 0; b3.addr = 0; b3.be = 0; b3.wdata = 0;
        rst0_n = 0; rst1_n = 0; rst2_n = 0; rst3_n = 0;

        // reset: outputs held low even with a request pending
        b0.req = 1'b1;
        b0.be  = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.gnt", 32'(b0.gnt), 32'd0);
        check("rst.rvalid", 32'(b0.rvalid), 32'd0);
        check("rst.rdata", b0.rdata, 32'd0);
        check("rst.err", 32'(b0.err), 32'd0);
        step();
        b0.req = 1'b0;
        rst0_n = 1; rst1_n = 1; rst2_n = 1; rst3_n = 1;

        // default instance: write/readback, byte lanes, range edges
        acc0(1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0, "wr10");
        acc0(0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0, "rd10");
        acc0(1, 32'h10, 4'b0010, 32'h00005500, 32'h0, 0, "wrb1");
        acc0(0, 32'h10, 4'hF, 32'h0, 32'hDEAD55EF, 0, "rdpart");
        acc0(1, 32'hFFC, 4'hF, 32'h12345678, 32'h0, 0, "wrlast");
        acc0(0, 32'hFFC, 4'hF, 32'h0, 32'h12345678, 0, "rdlast");
        acc0(0, 32'h1000, 4'hF, 32'h0, 32'h0, 1, "rdoor");
        acc0(1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1, "wroor");
        acc0(0, 32'hFFC, 4'hF, 32'h0, 32'h12345678, 0, "rdlast2");
        acc0(1, 32'h1010, 4'hF, 32'h0, 32'h0, 1, "wrwrap");
        acc0(0, 32'h10, 4'hF, 32'h0, 32'hDEAD55EF, 0, "rdnowrap");
        acc0(0, 32'h80000010, 4'hF, 32'h0, 32'h0, 1, "rdhigh");

        // grant stall of 3 cycles
        step();
        b1.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d.gnt", i), 32'(b1.gnt),
                  32'(i == 3));
            if (i < 3) step();
        end
        step();
        b1.req = 1'b0;
        @(negedge clk);
        check("stall.rvalid", 32'(b1.rvalid), 32'd1);

        // withdrawn request restarts the stall count
        step();
        b1.req = 1'b1;
        @(negedge clk);
        check("wd0.gnt", 32'(b1.gnt), 32'd0);
        step();
        @(negedge clk);
        check("wd1.gnt", 32'(b1.gnt), 32'd0);
        step();
        b1.req = 1'b0;
        @(negedge clk);
        check("wd.rvalid", 32'(b1.rvalid), 32'd0);
        step();
        b1.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("restall%0d.gnt", i), 32'(b1.gnt),
                  32'(i == 3));
            if (i < 3) step();
        end
        step();
        b1.req = 1'b0;
        @(negedge clk);
        check("restall.rvalid", 32'(b1.rvalid), 32'd1);

        // outstanding limit: latency 4, at most 2 in flight
        s_addr[0] = 32'h20;   s_we[0] = 1; s_wd[0] = 32'hA1A1A1A1;
        s_addr[1] = 32'h24;   s_we[1] = 1; s_wd[1] = 32'hB2B2B2B2;
        s_addr[2] = 32'h20;   s_we[2] = 0; s_wd[2] = 32'h0;
        s_addr[3] = 32'h24;   s_we[3] = 0; s_wd[3] = 32'h0;
        s_addr[4] = 32'h2000; s_we[4] = 0; s_wd[4] = 32'h0;
        s_addr[5] = 32'h20;   s_we[5] = 0; s_wd[5] = 32'h0;
        s_rd[0] = 0;            s_err[0] = 0;
        s_rd[1] = 0;            s_err[1] = 0;
        s_rd[2] = 32'hA1A1A1A1; s_err[2] = 0;
        s_rd[3] = 32'hB2B2B2B2; s_err[3] = 0;
        s_rd[4] = 0;            s_err[4] = 1;
        s_rd[5] = 32'hA1A1A1A1; s_err[5] = 0;
        k = 0;
        r = 0;
        b2.be = 4'hF;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step();
            if (k < 6) begin
                b2.req   = 1'b1;
                b2.addr  = s_addr[k];
                b2.we    = s_we[k];
                b2.wdata = s_wd[k];
            end else begin
                b2.req = 1'b0;
                b2.we  = 1'b0;
            end
            @(negedge clk);
            eg = (k < 6) && (((cyc - 1) % 4) < 2);
            ev = (cyc >= 5) && (cyc <= 14) && (((cyc - 1) % 4) < 2);
            check($sformatf("lim%0d.gnt", cyc), 32'(b2.gnt), 32'(eg));
            check($sformatf("lim%0d.rvalid", cyc), 32'(b2.rvalid),
                  32'(ev));
            if (b2.rvalid && r < 6) begin
                check($sformatf("lim.r%0d.rdata", r), b2.rdata, s_rd[r]);
                check($sformatf("lim.r%0d.err", r), 32'(b2.err),
                      32'(s_err[r]));
                r++;
            end
            if (b2.gnt) k++;
        end
        check("lim.grants", 32'(k), 32'd6);
        check("lim.resps", 32'(r), 32'd6);

        // reset mid-flight: latency 3
        step();
        b3.req   = 1'b1;
        b3.we    = 1'b1;
        b3.addr  = 32'h30;
        b3.be    = 4'hF;
        b3.wdata = 32'h5A5A0F0F;
        @(negedge clk);
        check("mf.wr.gnt", 32'(b3.gnt), 32'd1);
        step();
        b3.req = 1'b0;
        b3.we  = 1'b0;
        @(negedge clk);
        check("mf.wr.rv1", 32'(b3.rvalid), 32'd0);
        step();
        @(negedge clk);
        check("mf.wr.rv2", 32'(b3.rvalid), 32'd0);
        step();
        @(negedge clk);
        check("mf.wr.rv3", 32'(b3.rvalid), 32'd1);
        check("mf.wr.rdata", b3.rdata, 32'd0);
        step();
        b3.req  = 1'b1;
        b3.addr = 32'h30;
        @(negedge clk);
        check("mf.rd0.gnt", 32'(b3.gnt), 32'd1);
        step();
        b3.addr = 32'h34;
        @(negedge clk);
        check("mf.rd1.gnt", 32'(b3.gnt), 32'd1);
        step();
        rst3_n = 1'b0;
        @(negedge clk);
        check("mf.rst.gnt", 32'(b3.gnt), 32'd0);
        check("mf.rst.rvalid", 32'(b3.rvalid), 32'd0);
        check("mf.rst.rdata", b3.rdata, 32'd0);
        step();
        rst3_n = 1'b1;
        b3.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mf.drop%0d.rvalid", i), 32'(b3.rvalid),
                  32'd0);
            if (i < 2) step();
        end
        step();
        b3.req  = 1'b1;
        b3.addr = 32'h30;
        @(negedge clk);
        check("mf.new.gnt", 32'(b3.gnt), 32'd1);
        step();
        b3.req = 1'b0;
        @(negedge clk);
        check("mf.new.rv1", 32'(b3.rvalid), 32'd0);
        step();
        @(negedge clk);
        check("mf.new.rv2", 32'(b3.rvalid), 32'd0);
        step();
        @(negedge clk);
        check("mf.new.rvalid", 32'(b3.rvalid), 32'd1);
        check("mf.new.rdata", b3.rdata, 32'h5A5A0F0F);
        check("mf.new.err", 32'(b3.err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_stall_responder.md
# bus_stall_responder

Memory-backed device-side responder for the simple-system `req`/`gnt`/`rvalid` bus. It sits where a RAM or peripheral attaches to a `bus` device port, or directly on a core fetch or data port. It provides a word-addressed memory with programmable grant stalls, fixed in-order response latency, a bound on outstanding requests, and error responses for out-of-range addresses. Its purpose is to stress the core's LSU and fetch logic under non-ideal device timing.

## Interface
- `DataWidth`, 32: data bus width; must be 32.
- `AddressWidth`, 32: byte address width.
- `Depth`, 1024: memory size in 32-bit words.
- `GntStall`, 0: cycles a pending request waits before `gnt_o`; range 0..15.
- `RespLatency`, 1: cycles from acceptance edge to `rvalid_o`; range 1..8.
- `MaxOutstanding`, 2: maximum accepted-but-unresponded requests; range 1..RespLatency.

Ports:
- `clk_i`  in  1  clock. One clock domain.
- `rst_ni`  in  1  reset. Synchronous, active-low.
- `req_i`  in  1  request valid.
- `gnt_o`  out  1  request accepted this cycle.
- `addr_i`  in  AddressWidth  byte address. Bits [1:0] are ignored.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid. Exactly one per accepted request.
- `rdata_o`  out  32  read data.
- `err_o`  out  1  error response, qualified by `rvalid_o`.

## Operation
- Word index = `addr_i[AddressWidth-1:2]`. The address is in range iff word index < `Depth`.
- Acceptance: a request is accepted on a rising edge where `req_i && gnt_o`.
- Grant logic:
  - A 4-bit `stall_cnt` increments each cycle that `req_i` is high and `gnt_o` is low, saturating at `GntStall`.
  - `gnt_o = req_i && rst_ni && (stall_cnt == GntStall) && room`.
  - `room = (outstanding < MaxOutstanding) || rvalid_o`. A response retiring in the same cycle frees a slot.
  - `stall_cnt` clears on acceptance and whenever `req_i` is low.
  - With `GntStall=0`, `gnt_o` is combinational on `req_i`.
- Writes (in range) update the memory at the acceptance edge, per byte lane under `be_i`. The response carries `rdata_o=0` and `err_o=0`.
- Reads (in range) sample memory at the acceptance edge. A write accepted at an earlier edge is always visible to the read.
- Out-of-range access:
  - The memory is untouched.
  - The response carries `err_o=1` and `rdata_o=0`.
- Response pipeline: a `RespLatency`-deep shift register of {valid, err, data}. The accepted request enters stage 0, and the last stage drives the outputs. Order is strictly preserved.
- Outstanding counter:
  - +1 on acceptance, −1 on every cycle `rvalid_o` is high.
  - Both at once: the count is unchanged.
  - The count never exceeds `MaxOutstanding` and never underflows.
- The device has no back-pressure on responses. The host must sink `rvalid_o` every cycle it is high.

## Timing
- Reset:
  - On a rising edge with `rst_ni=0`, `stall_cnt`, `outstanding` and all pipeline valid bits clear.
  - `gnt_o=0`, `rvalid_o=0`, `rdata_o=0` and `err_o=0` are held while `rst_ni` is low.
  - Memory contents are not reset.
- Reset mid-operation drops in-flight responses. No `rvalid_o` is produced for requests accepted before the reset.
- Grant latency: `gnt_o` is first high in the (`GntStall`+1)th consecutive cycle of `req_i`, provided `room` holds.
- Response latency: a request accepted at edge E produces `rvalid_o` high in the cycle following edge E+`RespLatency`−1. With `RespLatency=1` this is the next cycle, matching `ram_2p`.
- Back-to-back acceptance: with `GntStall=0` and `MaxOutstanding=RespLatency`, one request per cycle is accepted. Responses then stream one per cycle.
- Withdrawn request: if `req_i` drops before grant, `stall_cnt` returns to 0. No response is issued.
- Boundary addresses:
  - Word index `Depth`−1 is valid; word index `Depth` errors.
  - No address wrap-around: the address is not taken modulo `Depth`.

## Test plan
- **Default parameters, write and readback:** write 0xDEADBEEF to 0x10 with `be=4'hF`, then read 0x10.
  - Write: `gnt_o` in the same cycle as `req_i`; `rvalid_o` the next cycle with `rdata_o=0`.
  - Read: `rvalid_o` with `rdata_o=0xDEADBEEF` and `err_o=0`.
- **Partial byte write:** after the test above, write 0x00005500 to 0x10 with `be=4'b0010`, then read 0x10. Required readback: 0xDEAD55EF.
- **Grant stall:** with `GntStall=3`, hold `req_i` high.
  - `gnt_o` stays low for 3 cycles and goes high in the 4th.
  - Drop `req_i` after 2 cycles and re-raise it: again 3 stall cycles before grant.
- **Outstanding limit:** with `RespLatency=4` and `MaxOutstanding=2`, issue reads continuously.
  - Two grants on consecutive cycles, then `gnt_o` low until the first `rvalid_o`. Grant resumes in that same cycle.
  - Response count equals grant count, and responses arrive in order.
- **Out-of-range access:** with `Depth=1024`, read 0x0FFC, then read 0x1000, then write 0x1000 and re-read 0x0FFC.
  - 0x0FFC responds `err_o=0`.
  - 0x1000 responds `err_o=1` with `rdata_o=0`.
  - The write to 0x1000 leaves the contents of 0x0FFC unchanged.
- **Reset mid-flight:** with `RespLatency=3`, accept 2 reads, then hold `rst_ni` low for 1 cycle.
  - `rvalid_o` never asserts for those reads.
  - After reset, a new read is granted with `GntStall`=0 timing and responds normally.
